// File: rtl/jpeg_idct_transpose_buf.sv
// jpeg_idct_transpose_buf: ping-pong 8x8 block buffer that streams each block out in column (or row) order
module jpeg_idct_transpose_buf #(
    parameter int DATA_W    = 16,
    parameter bit TRANSPOSE = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              inport_valid_i,
    input  logic [DATA_W-1:0] inport_data_i,
    output logic              inport_accept_o,
    output logic              outport_valid_o,
    output logic [DATA_W-1:0] outport_data_o,
    output logic              outport_last_o,
    input  logic              outport_accept_i,
    output logic              idle_o
);
    typedef enum logic [1:0] {EMPTY, FULL, DRAINING} bank_t;
    bank_t state [2];
    bank_t state_nxt [2];
    logic [DATA_W-1:0] mem [128];
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] fifo_data [2];
    logic [1:0] fifo_last;
    logic [1:0] count;
    logic [5:0] wr_idx, rd_idx, rd_addr;
    logic [2:0] occ;
    logic wr_bank, rd_bank, rd_pend, rd_last, wptr, rptr;
    logic clr, wr_en, wr_done, issue, rd_done, pop, fifo_pop, push;
    // The RAM output register acts as a bypass stage in front of the FIFO so the
    // first sample is visible the cycle after its read issues.
    always_comb begin
        clr             = rst_i | flush_i;
        inport_accept_o = (state[wr_bank] == EMPTY) & ~clr;
        wr_en           = inport_valid_i & inport_accept_o;
        wr_done         = wr_en & (wr_idx == 6'd63);
        outport_valid_o = (|count) | rd_pend;
        outport_data_o  = (|count) ? fifo_data[rptr] : rd_pend ? rd_q : '0;
        outport_last_o  = (|count) ? fifo_last[rptr] : rd_pend & rd_last;
        idle_o          = (state[0] == EMPTY) & (state[1] == EMPTY) & ~rd_pend & ~(|count);
        pop             = outport_valid_o & outport_accept_i;
        fifo_pop        = (|count) & outport_accept_i;
        push            = rd_pend & ~(~(|count) & outport_accept_i);
        occ             = {1'b0, count} + {2'b0, rd_pend} - {2'b0, pop};
        issue           = (state[rd_bank] != EMPTY) & (occ < 3'd2);
        rd_done         = issue & (rd_idx == 6'd63);
        rd_addr         = TRANSPOSE ? {rd_idx[2:0], rd_idx[5:3]} : rd_idx;
        state_nxt[0]    = (wr_done & ~wr_bank) ? FULL :
                          (issue & ~rd_bank) ? (rd_done ? EMPTY : DRAINING) : state[0];
        state_nxt[1]    = (wr_done & wr_bank) ? FULL :
                          (issue & rd_bank) ? (rd_done ? EMPTY : DRAINING) : state[1];
    end
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[{wr_bank, wr_idx}] <= inport_data_i;
        if (issue) begin
            rd_q    <= mem[{rd_bank, rd_addr}];
            rd_last <= rd_done;
        end
        if (push) begin
            fifo_data[wptr] <= rd_q;
            fifo_last[wptr] <= rd_last;
        end
    end
    always_ff @(posedge clk_i) begin
        if (clr) begin
            state[0] <= EMPTY;
            state[1] <= EMPTY;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_idx   <= '0;
            rd_idx   <= '0;
            rd_pend  <= 1'b0;
            wptr     <= 1'b0;
            rptr     <= 1'b0;
            count    <= '0;
        end else begin
            state[0] <= state_nxt[0];
            state[1] <= state_nxt[1];
            if (wr_en) wr_idx <= wr_idx + 6'd1;
            if (wr_done) wr_bank <= ~wr_bank;
            if (issue) rd_idx <= rd_idx + 6'd1;
            if (rd_done) rd_bank <= ~rd_bank;
            rd_pend <= issue;
            if (push) wptr <= ~wptr;
            if (fifo_pop) rptr <= ~rptr;
            count <= count + {1'b0, push} - {1'b0, fifo_pop};
        end
    end
endmodule
